// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared Connect-4 types, default sizes and cell indexing
//
// Purpose: common definitions for move_controller, the win checker and the display.
// Contents: default board size, derived widths, cell/state enums, cell-index helper.
package connect4_pkg;

  localparam int ROWS_DEF = 6;
  localparam int COLS_DEF = 7;
  localparam int ROW_W    = $clog2(ROWS_DEF);
  localparam int COL_W    = $clog2(COLS_DEF);
  localparam int CELLS    = ROWS_DEF * COLS_DEF;
  localparam int CNT_W    = $clog2(CELLS + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE,
    REJECT
  } mc_state_t;

  // Bit offset of cell (r,c) in the flattened board; each cell is 2 bits wide.
  function automatic int cell_idx(input int r, input int c, input int cols);
    return (r * cols + c) * 2;
  endfunction

endpackage

// File: rtl/move_controller.sv
// rtl/move_controller.sv - Connect-4 cursor, turn and board keeper with column drop
//
// Purpose: moves the cursor on left/right pulses, drops a piece into the lowest
// empty cell of the cursor column on a put, toggles the turn and reports the move.
// Ports:
//   clk, rst (async active-low), left_pulse/right_pulse/put_pulse (one-cycle requests),
//   game_over (freeze level), restart (sync clear)
//   cursor_col, cur_player, board (2 bits per cell, row 0 at bottom), busy,
//   move_done/move_row/move_col/move_player (placed-piece report), col_full, board_full
module move_controller
  import connect4_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      left_pulse,
  input  logic                      right_pulse,
  input  logic                      put_pulse,
  input  logic                      game_over,
  input  logic                      restart,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic                      cur_player,
  output logic [2*ROWS*COLS-1:0]    board,
  output logic                      busy,
  output logic                      move_done,
  output logic [$clog2(ROWS)-1:0]   move_row,
  output logic [$clog2(COLS)-1:0]   move_col,
  output logic                      move_player,
  output logic                      col_full,
  output logic                      board_full
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int NCELL = ROWS * COLS;
  localparam int NW    = $clog2(NCELL + 1);
  localparam int BW    = $clog2(2 * NCELL);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_HOME = CW'(COLS / 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [NW-1:0] CNT_MAX  = NW'(NCELL);

  mc_state_t          state_q, state_d;
  logic [CW-1:0]      cursor_q, cursor_d;
  logic [CW-1:0]      scan_col_q, scan_col_d;
  logic [CW-1:0]      move_col_q, move_col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [RW-1:0]      move_row_q, move_row_d;
  logic               cur_player_q, cur_player_d;
  logic               move_player_q, move_player_d;
  logic [2*NCELL-1:0] board_q, board_d;
  logic [NW-1:0]      count_q, count_d;
  logic               board_full_q, board_full_d;
  logic               move_done_q, move_done_d;
  logic               col_full_q, col_full_d;
  logic               busy_q, busy_d;

  logic [BW-1:0]      scan_bit;
  logic [1:0]         scan_cell;

  assign scan_bit  = BW'(cell_idx(int'(row_q), int'(scan_col_q), COLS));
  assign scan_cell = board_q[scan_bit +: 2];

  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    scan_col_d    = scan_col_q;
    move_col_d    = move_col_q;
    row_d         = row_q;
    move_row_d    = move_row_q;
    cur_player_d  = cur_player_q;
    move_player_d = move_player_q;
    board_d       = board_q;
    count_d       = count_q;
    board_full_d  = board_full_q;

    case (state_q)
      IDLE: begin
        if (game_over || board_full_q) begin
          // frozen: every request is dropped
        end else if (put_pulse) begin
          scan_col_d = cursor_q;
          row_d      = '0;
          state_d    = SCAN;
        end else if (right_pulse && !left_pulse) begin
          cursor_d = (cursor_q == COL_LAST) ? '0 : cursor_q + 1'b1;
        end else if (left_pulse && !right_pulse) begin
          cursor_d = (cursor_q == '0) ? COL_LAST : cursor_q - 1'b1;
        end
      end
      SCAN: begin
        if (scan_cell == EMPTY) begin
          board_d[scan_bit +: 2] = cur_player_q ? P2 : P1;
          move_row_d    = row_q;
          move_col_d    = scan_col_q;
          move_player_d = cur_player_q;
          state_d       = DONE;
        end else if (row_q != ROW_LAST) begin
          row_d = row_q + 1'b1;
        end else begin
          state_d = REJECT;
        end
      end
      DONE: begin
        cur_player_d = ~cur_player_q;
        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
        board_full_d = (count_d == CNT_MAX);
        state_d      = IDLE;
      end
      REJECT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pulses and busy are registered copies of the state being entered.
    move_done_d = (state_d == DONE);
    col_full_d  = (state_d == REJECT);
    busy_d      = (state_d != IDLE);

    // Restart wins over everything, including a scan in flight.
    if (restart) begin
      state_d       = IDLE;
      cursor_d      = COL_HOME;
      scan_col_d    = '0;
      move_col_d    = '0;
      row_d         = '0;
      move_row_d    = '0;
      cur_player_d  = 1'b0;
      move_player_d = 1'b0;
      board_d       = '0;
      count_d       = '0;
      board_full_d  = 1'b0;
      move_done_d   = 1'b0;
      col_full_d    = 1'b0;
      busy_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cursor_q      <= COL_HOME;
      scan_col_q    <= '0;
      move_col_q    <= '0;
      row_q         <= '0;
      move_row_q    <= '0;
      cur_player_q  <= 1'b0;
      move_player_q <= 1'b0;
      board_q       <= '0;
      count_q       <= '0;
      board_full_q  <= 1'b0;
      move_done_q   <= 1'b0;
      col_full_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      scan_col_q    <= scan_col_d;
      move_col_q    <= move_col_d;
      row_q         <= row_d;
      move_row_q    <= move_row_d;
      cur_player_q  <= cur_player_d;
      move_player_q <= move_player_d;
      board_q       <= board_d;
      count_q       <= count_d;
      board_full_q  <= board_full_d;
      move_done_q   <= move_done_d;
      col_full_q    <= col_full_d;
      busy_q        <= busy_d;
    end
  end

  assign cursor_col  = cursor_q;
  assign cur_player  = cur_player_q;
  assign board       = board_q;
  assign busy        = busy_q;
  assign move_done   = move_done_q;
  assign move_row    = move_row_q;
  assign move_col    = move_col_q;
  assign move_player = move_player_q;
  assign col_full    = col_full_q;
  assign board_full  = board_full_q;

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - self-checking bench for move_controller
module tb_move_controller;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        left_pulse = 1'b0, right_pulse = 1'b0, put_pulse = 1'b0;
  logic        game_over = 1'b0, restart = 1'b0;
  logic [2:0]  cursor_col;
  logic        cur_player;
  logic [83:0] board;
  logic        busy, move_done, move_player, col_full, board_full;
  logic [2:0]  move_row;
  logic [2:0]  move_col;

  move_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst_n),
    .left_pulse(left_pulse), .right_pulse(right_pulse), .put_pulse(put_pulse),
    .game_over(game_over), .restart(restart),
    .cursor_col(cursor_col), .cur_player(cur_player), .board(board), .busy(busy),
    .move_done(move_done), .move_row(move_row), .move_col(move_col),
    .move_player(move_player), .col_full(col_full), .board_full(board_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    bit player;
    int lat;
    bit rej;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          m_height[COLS];
  int          m_cursor;
  bit          m_player;
  int          m_count;
  logic [83:0] m_board;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) m_height[c] = 0;
    m_cursor = 3;
    m_player = 1'b0;
    m_count  = 0;
    m_board  = '0;
    sb.delete();
  endtask

  // Predict the outcome of a put in column col and queue it.
  task automatic push_put(input int col);
    exp_t e;
    e.col    = col;
    e.player = m_player;
    if (m_height[col] >= ROWS) begin
      e.rej = 1'b1;
      e.row = 0;
      e.lat = 1 + ROWS;
    end else begin
      e.rej = 1'b0;
      e.row = m_height[col];
      e.lat = 2 + e.row;
      m_board[(e.row * COLS + col) * 2 +: 2] = m_player ? 2'b10 : 2'b01;
      m_height[col]++;
      m_player = ~m_player;
      m_count++;
    end
    sb.push_back(e);
  endtask

  // Pulse put, wait (bounded) for move_done or col_full, then one more cycle back to IDLE.
  task automatic do_put(input bit noise, output int edges, output bit got_done, output bit got_full);
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    edges = 1;
    got_done = 1'b0;
    got_full = 1'b0;
    while (edges < 20) begin
      if (move_done) got_done = 1'b1;
      if (col_full) got_full = 1'b1;
      if (got_done || got_full) break;
      if (noise) begin
        put_pulse   = (edges % 3 == 0);
        left_pulse  = (edges % 3 == 1);
        right_pulse = (edges % 3 == 2);
      end
      tick();
      put_pulse = 1'b0; left_pulse = 1'b0; right_pulse = 1'b0;
      edges++;
    end
    tick();
  endtask

  task automatic pulse_lr(input bit l, input bit r);
    left_pulse = l;
    right_pulse = r;
    tick();
    left_pulse = 1'b0;
    right_pulse = 1'b0;
  endtask

  task automatic move_to(input int col);
    for (int i = 0; i < COLS && m_cursor != col; i++) begin
      pulse_lr(1'b0, 1'b1);
      m_cursor = (m_cursor + 1) % COLS;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int e; bit d, f;
    model_clear();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (cursor_col !== 3'd3 || cur_player !== 1'b0 || board !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: cursor=%0d player=%0d board=%h busy=%0d, need 3/0/0/0",
               cursor_col, cur_player, board, busy);
    end
    // Mid-run: make a move, start another, reset during its scan.
    pulse_lr(1'b0, 1'b1);
    do_put(1'b0, e, d, f);
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || board !== '0 || cursor_col !== 3'd3) begin
      fails++;
      $display("FAIL reset_async: busy=%0d board=%h cursor=%0d, need 0/0/3", busy, board, cursor_col);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (cursor_col !== 3'd3 || cur_player !== 1'b0 || board !== '0 || busy !== 1'b0 ||
        move_done !== 1'b0 || col_full !== 1'b0 || board_full !== 1'b0 ||
        move_row !== 3'd0 || move_col !== 3'd0 || move_player !== 1'b0) begin
      fails++;
      $display("FAIL reset_midrun: cursor=%0d player=%0d busy=%0d done=%0d full=%0d bfull=%0d mrow=%0d mcol=%0d mpl=%0d, need 3 and all 0",
               cursor_col, cur_player, busy, move_done, col_full, board_full, move_row, move_col, move_player);
    end
    model_clear();
  endtask

  task automatic test_cursor_wrap();
    int exp_c[4] = '{4, 5, 6, 0};
    for (int i = 0; i < 4; i++) begin
      pulse_lr(1'b0, 1'b1);
      tests++;
      if (cursor_col !== 3'(exp_c[i])) begin
        fails++;
        $display("FAIL cursor_right_%0d: got %0d, need %0d", i, cursor_col, exp_c[i]);
      end
    end
    pulse_lr(1'b1, 1'b0);
    tests++;
    if (cursor_col !== 3'd6) begin
      fails++;
      $display("FAIL cursor_left_wrap: got %0d, need 6", cursor_col);
    end
    pulse_lr(1'b1, 1'b1);
    tests++;
    if (cursor_col !== 3'd6) begin
      fails++;
      $display("FAIL cursor_both: got %0d, need 6", cursor_col);
    end
    m_cursor = 6;
  endtask

  task automatic test_single_drop();
    int e; bit d, f; exp_t x;
    move_to(3);
    for (int k = 0; k < 2; k++) begin
      push_put(3);
      do_put(1'b0, e, d, f);
      x = sb.pop_front();
      tests++;
      if (d !== 1'b1 || f !== 1'b0 || e != x.lat) begin
        fails++;
        $display("FAIL drop_%0d_latency: done=%0d full=%0d cycles=%0d, need 1/0/%0d", k, d, f, e, x.lat);
      end
      tests++;
      if (move_row !== 3'(x.row) || move_col !== 3'(x.col) || move_player !== x.player) begin
        fails++;
        $display("FAIL drop_%0d_report: row=%0d col=%0d pl=%0d, need %0d/%0d/%0d",
                 k, move_row, move_col, move_player, x.row, x.col, x.player);
      end
      tests++;
      if (board !== m_board || cur_player !== m_player) begin
        fails++;
        $display("FAIL drop_%0d_board: board=%h player=%0d, need %h/%0d", k, board, cur_player, m_board, m_player);
      end
    end
  endtask

  task automatic test_col_full();
    int e; bit d, f; exp_t x;
    do_restart();
    move_to(0);
    for (int k = 0; k <= ROWS; k++) begin
      push_put(0);
      do_put(1'b1, e, d, f);
      x = sb.pop_front();
      tests++;
      if (d !== !x.rej || f !== x.rej || e != x.lat) begin
        fails++;
        $display("FAIL colfull_put_%0d: done=%0d full=%0d cycles=%0d, need %0d/%0d/%0d",
                 k, d, f, e, !x.rej, x.rej, x.lat);
      end
    end
    tests++;
    if (board !== m_board || cur_player !== m_player || cursor_col !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL colfull_state: board=%h player=%0d cursor=%0d busy=%0d, need %h/%0d/0/0",
               board, cur_player, cursor_col, busy, m_board, m_player);
    end
  endtask

  task automatic test_board_full();
    int e; bit d, f; exp_t x;
    do_restart();
    for (int c = 0; c < COLS; c++) begin
      move_to(c);
      for (int k = 0; k < ROWS; k++) begin
        push_put(c);
        do_put(1'b0, e, d, f);
        x = sb.pop_front();
        tests++;
        if (d !== 1'b1 || e != x.lat || move_row !== 3'(x.row) || move_col !== 3'(x.col) ||
            move_player !== x.player || board_full !== (m_count == ROWS * COLS)) begin
          fails++;
          $display("FAIL fill_c%0d_k%0d: done=%0d cycles=%0d row=%0d col=%0d pl=%0d bfull=%0d, need 1/%0d/%0d/%0d/%0d/%0d",
                   c, k, d, e, move_row, move_col, move_player, board_full,
                   x.lat, x.row, x.col, x.player, (m_count == ROWS * COLS));
        end
      end
    end
    tests++;
    if (board !== m_board || board_full !== 1'b1) begin
      fails++;
      $display("FAIL board_full_state: board=%h bfull=%0d, need %h/1", board, board_full, m_board);
    end
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    pulse_lr(1'b1, 1'b0);
    tests++;
    if (busy !== 1'b0 || board !== m_board || cursor_col !== 3'(m_cursor) || cur_player !== m_player) begin
      fails++;
      $display("FAIL board_full_freeze: busy=%0d cursor=%0d player=%0d, need 0/%0d/%0d",
               busy, cursor_col, cur_player, m_cursor, m_player);
    end
  endtask

  task automatic test_game_over();
    int e; bit d, f; exp_t x;
    do_restart();
    game_over = 1'b1;
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    tick();
    pulse_lr(1'b0, 1'b1);
    pulse_lr(1'b1, 1'b0);
    tests++;
    if (busy !== 1'b0 || board !== '0 || cursor_col !== 3'd3 || cur_player !== 1'b0) begin
      fails++;
      $display("FAIL game_over_freeze: busy=%0d board=%h cursor=%0d player=%0d, need 0/0/3/0",
               busy, board, cursor_col, cur_player);
    end
    // game_over rising mid-scan must not abort the move in flight.
    game_over = 1'b0;
    push_put(3);
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    game_over = 1'b1;
    e = 1;
    d = 1'b0;
    while (e < 20 && !d) begin
      if (move_done) d = 1'b1;
      else begin tick(); e++; end
    end
    x = sb.pop_front();
    tests++;
    if (d !== 1'b1 || e != x.lat || move_row !== 3'(x.row) || move_col !== 3'(x.col)) begin
      fails++;
      $display("FAIL game_over_inflight: done=%0d cycles=%0d row=%0d col=%0d, need 1/%0d/%0d/%0d",
               d, e, move_row, move_col, x.lat, x.row, x.col);
    end
    tick();
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    tests++;
    if (busy !== 1'b0 || board !== m_board || cur_player !== m_player) begin
      fails++;
      $display("FAIL game_over_after: busy=%0d board=%h player=%0d, need 0/%h/%0d",
               busy, board, cur_player, m_board, m_player);
    end
    game_over = 1'b0;
  endtask

  task automatic test_restart_scan();
    int e; bit d, f; bit seen;
    do_restart();
    move_to(2);
    for (int k = 0; k < 4; k++) begin
      push_put(2);
      do_put(1'b0, e, d, f);
      void'(sb.pop_front());
    end
    tests++;
    if (board !== m_board) begin
      fails++;
      $display("FAIL restart_prefill: board=%h, need %h", board, m_board);
    end
    seen = 1'b0;
    put_pulse = 1'b1;
    tick();
    put_pulse = 1'b0;
    seen |= move_done | col_full;
    tick();
    seen |= move_done | col_full;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_clear();
    tests++;
    if (busy !== 1'b0 || board !== '0 || cursor_col !== 3'd3 || cur_player !== 1'b0 ||
        move_done !== 1'b0 || col_full !== 1'b0 || move_row !== 3'd0 || move_col !== 3'd0) begin
      fails++;
      $display("FAIL restart_scan_state: busy=%0d board=%h cursor=%0d player=%0d done=%0d mrow=%0d mcol=%0d, need 0/0/3/0/0/0/0",
               busy, board, cursor_col, cur_player, move_done, move_row, move_col);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= move_done | col_full;
    end
    tests++;
    if (seen !== 1'b0 || board !== '0) begin
      fails++;
      $display("FAIL restart_scan_pulse: pulse_seen=%0d board=%h, need 0/0", seen, board);
    end
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_single_drop();
    test_col_full();
    test_board_full();
    test_game_over();
    test_restart_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
